// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_adder_if
// Purpose : Operand/result handshake bundle for pipelined_adder.
// Rev     : 1.0  initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] firstInput;
    logic [WIDTH-1:0] secondInput;
    logic             carryIn;
    logic             subtract;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] out;
    logic             carryOut;
    logic             overflow;
    logic             zero;

    modport slave (
        input  inValid, firstInput, secondInput, carryIn, subtract, outReady,
        output inReady, outValid, out, carryOut, overflow, zero
    );

    modport master (
        output inValid, firstInput, secondInput, carryIn, subtract, outReady,
        input  inReady, outValid, out, carryOut, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_adder
// Purpose : STAGES-deep add/subtract pipeline, one CW-bit carry chunk per stage.
// Rev     : 1.0  initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input wire               clk,
    input wire               rst,
    pipelined_adder_if.slave io
);
    localparam int CW = WIDTH / STAGES;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CW;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [CW:0]      chunk_sum;
        logic [LO+CW-1:0] res_next;
        logic [LO+CW-1:0] res_q;
        logic             c_q;
        logic             v_q;
        logic             adv;

        assign chunk_sum = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        if (k == 0) begin : g_head
            assign a_in       = io.firstInput;
            assign b_in       = io.subtract ? ~io.secondInput : io.secondInput;
            assign c_in       = io.carryIn ^ io.subtract;
            assign v_in       = io.inValid;
            assign res_next   = chunk_sum[CW-1:0];
            assign io.inReady = adv;
        end else begin : g_body
            assign a_in     = g_stage[k-1].g_skew.a_q;
            assign b_in     = g_stage[k-1].g_skew.b_q;
            assign c_in     = g_stage[k-1].c_q;
            assign v_in     = g_stage[k-1].v_q;
            assign res_next = {chunk_sum[CW-1:0], g_stage[k-1].res_q};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= chunk_sum[CW];
                res_q <= res_next;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            // Operand bits not yet summed ride along with their beat
            logic [REM-CW-1:0] a_q;
            logic [REM-CW-1:0] b_q;

            assign adv = !v_q || g_stage[k+1].adv;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[REM-1:CW];
                    b_q <= b_in[REM-1:CW];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            assign adv = !v_q || io.outReady;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[REM-1] == b_in[REM-1]) && (chunk_sum[CW-1] != a_in[REM-1]);
                    zero_q <= (res_next == '0);
                end
            end

            assign io.outValid = v_q;
            assign io.out      = res_q;
            assign io.carryOut = c_q;
            assign io.overflow = ovf_q;
            assign io.zero     = zero_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipelined_adder
// Purpose : Scoreboard bench for 1-, 4- and 8-stage builds of pipelined_adder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [31:0] out;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  en = 3'b010;
    int          n_checks = 0;
    int          n_fail = 0;
    res_t        q1[$];
    res_t        q4[$];
    res_t        q8[$];

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) if1 ();
    pipelined_adder_if #(.WIDTH(WIDTH)) if4 ();
    pipelined_adder_if #(.WIDTH(WIDTH)) if8 ();

    assign if1.inValid = in_valid & en[0];
    assign if1.firstInput = a;
    assign if1.secondInput = b;
    assign if1.carryIn = cin;
    assign if1.subtract = sub;
    assign if1.outReady = out_ready;

    assign if4.inValid = in_valid & en[1];
    assign if4.firstInput = a;
    assign if4.secondInput = b;
    assign if4.carryIn = cin;
    assign if4.subtract = sub;
    assign if4.outReady = out_ready;

    assign if8.inValid = in_valid & en[2];
    assign if8.firstInput = a;
    assign if8.secondInput = b;
    assign if8.carryIn = cin;
    assign if8.subtract = sub;
    assign if8.outReady = out_ready;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .io(if1));
    pipelined_adder #(.WIDTH(WIDTH), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .io(if4));
    pipelined_adder #(.WIDTH(WIDTH), .STAGES(8)) dut8 (.clk(clk), .rst(rst), .io(if8));

    // Reference: true integer arithmetic, then range-check for signed overflow
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        longint ux, uy, sx, sy, u, s;
        res_t   r;
        ux = {32'h0, x};
        uy = {32'h0, y};
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (sb) begin
            u   = ux - uy - longint'(ci);
            s   = sx - sy - longint'(ci);
            r.c = (u >= 0);
        end else begin
            u   = ux + uy + longint'(ci);
            s   = sx + sy + longint'(ci);
            r.c = u[32];
        end
        r.out = u[31:0];
        r.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.z   = (r.out == 32'h0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if1.inValid && if1.inReady) q1.push_back(model(a, b, cin, sub));
            if (if4.inValid && if4.inReady) q4.push_back(model(a, b, cin, sub));
            if (if8.inValid && if8.inReady) q8.push_back(model(a, b, cin, sub));
            if (if1.outValid && if1.outReady) begin
                chk("s1_pending", 64'(q1.size() != 0), 1);
                if (q1.size() != 0)
                    chk("s1_result", {if1.out, if1.carryOut, if1.overflow, if1.zero}, q1.pop_front());
            end
            if (if4.outValid && if4.outReady) begin
                chk("s4_pending", 64'(q4.size() != 0), 1);
                if (q4.size() != 0)
                    chk("s4_result", {if4.out, if4.carryOut, if4.overflow, if4.zero}, q4.pop_front());
            end
            if (if8.outValid && if8.outReady) begin
                chk("s8_pending", 64'(q8.size() != 0), 1);
                if (q8.size() != 0)
                    chk("s8_result", {if8.out, if8.carryOut, if8.overflow, if8.zero}, q8.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat on the 4-stage build, checked against literal expectations
    task automatic directed(input string name, input logic [31:0] ta, input logic [31:0] tbv,
                            input logic tc, input logic ts, input logic [34:0] exp);
        int lat;
        lat = 0;
        en = 3'b010;
        out_ready = 1'b1;
        a = ta; b = tbv; cin = tc; sub = ts;
        in_valid = 1'b1;
        #1;
        chk({name, "_ready"}, 64'(if4.inReady), 1);
        do begin
            tick();
            in_valid = 1'b0;
            lat++;
        end while (!if4.outValid && lat < 20);
        chk({name, "_lat"}, 64'(lat), 4);
        chk({name, "_val"}, {if4.out, if4.carryOut, if4.overflow, if4.zero}, 64'(exp));
    endtask

    initial begin
        int acc, hs, gaps, spurious, l1, l4, l8, n1, n4, n8, cyc;
        res_t snap;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'({if1.outValid, if4.outValid, if8.outValid}), 0);
        chk("rst_out", {if4.out, if4.carryOut, if4.overflow, if4.zero}, 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 64'({if1.inReady, if4.inReady, if8.inReady}), 3'b111);

        directed("max_plus_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h0, 1'b1, 1'b0, 1'b1});
        directed("pos_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        directed("sub_neg",    32'h5, 32'h7, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        directed("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1, {32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0});
        directed("sub_zero",   32'h5, 32'h5, 1'b0, 1'b1, {32'h0, 1'b1, 1'b0, 1'b1});
        directed("sub_ovf",    32'h8000_0000, 32'h1, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        directed("add_cin",    32'h1, 32'h2, 1'b1, 1'b0, {32'h4, 1'b0, 1'b0, 1'b0});

        // Backpressure: fill with consumer stalled, then drain
        tick();
        en = 3'b010;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            a = 32'(acc); b = 32'(acc * 16); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            #1;
            if (if4.inReady) acc++;
            tick();
        end
        chk("bp_accepted", 64'(acc), 4);
        chk("bp_inready", 64'(if4.inReady), 0);
        chk("bp_outvalid", 64'(if4.outValid), 1);
        snap = {if4.out, if4.carryOut, if4.overflow, if4.zero};
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold", {if4.out, if4.carryOut, if4.overflow, if4.zero}, snap);
        end
        out_ready = 1'b1;
        hs = 0;
        gaps = 0;
        for (int c = 0; c < 20 && hs < 8; c++) begin
            a = 32'(acc); b = 32'(acc * 16); in_valid = (acc < 8);
            #1;
            if (if4.outValid) hs++; else gaps++;
            if (in_valid && if4.inReady) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_drained", 64'(hs), 8);
        chk("bp_gaps", 64'(gaps), 0);
        chk("bp_all_in", 64'(acc), 8);

        // Reset with beats in flight
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = 32'(100 + c); b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("rst_mid_pre", 64'(if4.outValid), 1);
        #1;
        rst = 1'b1;
        q1.delete(); q4.delete(); q8.delete();
        #1;
        chk("rst_mid_valid", 64'({if1.outValid, if4.outValid, if8.outValid}), 0);
        chk("rst_mid_out", {if4.out, if4.carryOut, if4.overflow, if4.zero}, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if4.outValid) spurious++;
        end
        chk("rst_no_stale", 64'(spurious), 0);
        directed("post_rst", 32'h1, 32'h2, 1'b0, 1'b0, {32'h3, 1'b0, 1'b0, 1'b0});

        // Unstalled latency for all three builds
        tick();
        tick();
        en = 3'b111;
        out_ready = 1'b1;
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        l1 = 0; l4 = 0; l8 = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            in_valid = 1'b0;
            if (l1 == 0 && if1.outValid) l1 = e;
            if (l4 == 0 && if4.outValid) l4 = e;
            if (l8 == 0 && if8.outValid) l8 = e;
        end
        chk("lat_s1", 64'(l1), 1);
        chk("lat_s4", 64'(l4), 4);
        chk("lat_s8", 64'(l8), 8);

        // Random stream with random consumer stalls
        n1 = 0; n4 = 0; n8 = 0; cyc = 0;
        while ((n1 < 1000 || n4 < 1000 || n8 < 1000) && cyc < 6000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && if1.inReady) n1++;
            if (in_valid && if4.inReady) n4++;
            if (in_valid && if8.inReady) n8++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_beats", 64'(n1 >= 1000 && n4 >= 1000 && n8 >= 1000), 1);
        for (int c = 0; c < 40 && (q1.size() + q4.size() + q8.size()) != 0; c++) tick();
        chk("rand_drain", 64'(q1.size() + q4.size() + q8.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
